// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl_pkg
// Purpose  : Shared types and helpers for the shift-register window
//            controller. This package holds the controller state encoding and
//            the counter width helper used by the top and its counters.
// Revision : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    // Controller states:
    //   FILL - collecting a fresh window
    //   WIN  - window presented downstream
    //   STEP - advancing the window by the stride
    typedef enum logic [1:0] {
        FILL = 2'd0,
        WIN  = 2'd1,
        STEP = 2'd2
    } win_state_e;

    // Returns the number of bits needed to count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_window_ctrl_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Up-counter with clear and increment enable. The counter wraps
//            naturally at 2^WIDTH. Clear has priority over increment.
// Ports    : clk_i     - clock, rising edge
//            reset_n_i - asynchronous active-low reset
//            clear_i   - synchronous clear to zero
//            inc_i     - increment by one
//            count_o   - current count
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (inc_i) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/shift_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_window_ctrl
// Purpose  : Sequencer for the shift-register window buffer in front of the
//            FIR/CNN conv stage. It takes an upstream valid/ready sample
//            stream, drives the buffer shift enable, and presents a full
//            window until downstream accepts it. STRIDE new samples are
//            taken between windows, and the fill restarts after last_i.
// Ports    : clk_i       - clock, rising edge
//            reset_n_i   - asynchronous active-low reset
//            valid_i     - upstream sample valid
//            last_i      - final sample of the sequence (qualifies valid_i)
//            ready_o     - controller can take a sample
//            shift_en_o  - shift strobe to the window buffer
//            valid_o     - buffer holds a complete window
//            ready_i     - downstream consumes the window
//            fill_cnt_o  - samples currently held in the window
//            win_idx_o   - index of the presented window (optional)
// Config   : `SHIFT_WINDOW_CTRL_IDX_EN adds the win_idx_o window index counter.
// Revision : 1.0 - initial release
// ============================================================================
module shift_window_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int REGISTER_LENGTH = 10,
    parameter  int STRIDE          = 1,
    localparam int CNT_W           = cnt_width(REGISTER_LENGTH)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             valid_i,
    input  logic             last_i,
    output logic             ready_o,
    output logic             shift_en_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] fill_cnt_o
`ifdef SHIFT_WINDOW_CTRL_IDX_EN
    ,
    output logic [15:0]      win_idx_o
`endif
);

    localparam logic [CNT_W-1:0] c_FULL      = CNT_W'(REGISTER_LENGTH);
    localparam logic [CNT_W-1:0] c_FULL_M1   = CNT_W'(REGISTER_LENGTH - 1);
    localparam logic [CNT_W-1:0] c_STRIDE_M1 = CNT_W'(STRIDE - 1);

    if ((REGISTER_LENGTH < 2) || (STRIDE < 1) || (STRIDE > REGISTER_LENGTH)) begin : g_bad_params
        $error("shift_window_ctrl: invalid REGISTER_LENGTH/STRIDE combination");
    end

    win_state_e       r_state;
    win_state_e       w_next_state;
    logic             r_last_seen;
    logic [CNT_W-1:0] w_fill_cnt;
    logic [CNT_W-1:0] w_stride_cnt;
    logic             w_ready;
    logic             w_accept;
    logic             w_fill_inc;
    logic             w_fill_clr;
    logic             w_stride_inc;
    logic             w_stride_clr;
    logic             w_set_last;
    logic             w_clr_last;

    // Gating ready with reset keeps the buffer from shifting while the
    // controller is held in reset.
    assign w_ready  = reset_n_i && (r_state != WIN);
    assign w_accept = valid_i && w_ready;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= FILL;
            r_last_seen <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_last) begin
                r_last_seen <= 1'b1;
            end else if (w_clr_last) begin
                r_last_seen <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_fill_inc   = 1'b0;
        w_fill_clr   = 1'b0;
        w_stride_inc = 1'b0;
        w_stride_clr = 1'b0;
        w_set_last   = 1'b0;
        w_clr_last   = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (w_fill_cnt == c_FULL_M1) begin
                        // last_i on the completing sample still yields a window.
                        w_fill_inc   = 1'b1;
                        w_next_state = WIN;
                        w_set_last   = last_i;
                    end else if (last_i) begin
                        // Sequence ended before the window filled: drop it.
                        w_fill_clr = 1'b1;
                    end else begin
                        w_fill_inc = (w_fill_cnt != c_FULL);
                    end
                end
            end
            WIN: begin
                if (ready_i) begin
                    if (r_last_seen) begin
                        w_next_state = FILL;
                        w_fill_clr   = 1'b1;
                        w_clr_last   = 1'b1;
                    end else begin
                        w_next_state = STEP;
                        w_stride_clr = 1'b1;
                    end
                end
            end
            STEP: begin
                if (w_accept) begin
                    w_stride_inc = 1'b1;
                    w_set_last   = last_i;
                    // A short stride is presented if the sequence ends early.
                    if (last_i || (w_stride_cnt == c_STRIDE_M1)) begin
                        w_next_state = WIN;
                    end
                end
            end
            default: begin
                w_next_state = FILL;
            end
        endcase
    end

    mod_counter #(.WIDTH(CNT_W)) u_fill_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (w_fill_clr),
        .inc_i     (w_fill_inc),
        .count_o   (w_fill_cnt)
    );

    mod_counter #(.WIDTH(CNT_W)) u_stride_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (w_stride_clr),
        .inc_i     (w_stride_inc),
        .count_o   (w_stride_cnt)
    );

`ifdef SHIFT_WINDOW_CTRL_IDX_EN
    // The final window of a sequence increments and clears on the same
    // edge; the clear wins so the next sequence starts at index 0.
    mod_counter #(.WIDTH(16)) u_win_idx (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (w_clr_last),
        .inc_i     ((r_state == WIN) && ready_i),
        .count_o   (win_idx_o)
    );
`endif

    assign ready_o    = w_ready;
    assign shift_en_o = w_accept;
    assign valid_o    = (r_state == WIN);
    assign fill_cnt_o = w_fill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_window_ctrl
// Purpose  : Self-checking bench for shift_window_ctrl with REGISTER_LENGTH=4
//            and STRIDE=2. It includes a behavioural 4x8-bit window buffer in
//            which the newest sample enters the top byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_window_ctrl;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [7:0]  din = 8'd0;
    logic        ready_o;
    logic        shift_en_o;
    logic        valid_o;
    logic [2:0]  fill_cnt_o;
    logic [31:0] win_data = 32'd0;
`ifdef SHIFT_WINDOW_CTRL_IDX_EN
    logic [15:0] win_idx_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_window_ctrl #(.REGISTER_LENGTH(4), .STRIDE(2)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .ready_o    (ready_o),
        .shift_en_o (shift_en_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .fill_cnt_o (fill_cnt_o)
`ifdef SHIFT_WINDOW_CTRL_IDX_EN
        ,
        .win_idx_o  (win_idx_o)
`endif
    );

    // Window buffer: not reset, newest sample in the top byte.
    always @(posedge clk) begin
        if (shift_en_o) win_data <= {din, win_data[31:8]};
    end

    typedef struct packed {
        logic        v;
        logic        l;
        logic        r;
        logic [7:0]  d;
        logic        e_ready;
        logic        e_shen;
        logic        e_valid;
        logic [2:0]  e_fill;
        logic        chk_data;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and settle
    // before sampling.
    task automatic cyc(input logic v, input logic l, input logic r, input logic [7:0] d);
        @(posedge clk);
        #1;
        valid_i = v;
        last_i  = l;
        ready_i = r;
        din     = d;
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        valid_i   = 1'b0;
        last_i    = 1'b0;
        ready_i   = 1'b0;
        reset_n_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n_i = 1'b1;
        #1;
        chk("reset_valid", {31'd0, valid_o}, 32'd0);
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        chk("reset_fill", {29'd0, fill_cnt_o}, 32'd0);
        chk("reset_shen", {31'd0, shift_en_o}, 32'd0);
    endtask

    initial begin
        // v l r d | ready shen valid fill chkd data
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h04030201};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h04030201};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h04030201};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h04030201};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h04030201};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h04030201};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'd6, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h06050403};

        do_reset();

        // Fill, hold, stride step (table driven)
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_ready", i), {31'd0, ready_o}, {31'd0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_shen", i), {31'd0, shift_en_o}, {31'd0, tbl[i].e_shen});
            chk($sformatf("tbl%0d_valid", i), {31'd0, valid_o}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_fill", i), {29'd0, fill_cnt_o}, {29'd0, tbl[i].e_fill});
            if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), win_data, tbl[i].e_data);
        end

        // Continuous streaming: one window every STRIDE+1 cycles
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 1'b0, 1'b1, 8'(20 + k));
            chk($sformatf("stream%0d_valid", k), {31'd0, valid_o}, {31'd0, (k % 3) == 0});
            chk($sformatf("stream%0d_shen", k), {31'd0, shift_en_o}, {31'd0, (k % 3) != 0});
        end

        // last_i on the first stride sample
        do_reset();
        for (int s = 1; s <= 4; s++) cyc(1'b1, 1'b0, 1'b0, 8'(s));
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        chk("t5_win1_valid", {31'd0, valid_o}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'd5);
        chk("t5_step_shen", {31'd0, shift_en_o}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t5_short_valid", {31'd0, valid_o}, 32'd1);
        chk("t5_short_data", win_data, 32'h05040302);
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        chk("t5_ack_valid", {31'd0, valid_o}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t5_end_valid", {31'd0, valid_o}, 32'd0);
        chk("t5_end_ready", {31'd0, ready_o}, 32'd1);
        chk("t5_end_fill", {29'd0, fill_cnt_o}, 32'd0);

        // last_i mid-fill discards the partial window
        cyc(1'b1, 1'b0, 1'b0, 8'd1);
        chk("t4_s1_shen", {31'd0, shift_en_o}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'd2);
        chk("t4_s2_fill", {29'd0, fill_cnt_o}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t4_drop_fill", {29'd0, fill_cnt_o}, 32'd0);
        chk("t4_drop_valid", {31'd0, valid_o}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd11);
        cyc(1'b1, 1'b0, 1'b0, 8'd12);
        cyc(1'b1, 1'b0, 1'b0, 8'd13);
        chk("t4_s13_valid", {31'd0, valid_o}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 8'd14);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t4_win_valid", {31'd0, valid_o}, 32'd1);
        chk("t4_win_data", win_data, 32'h0e0d0c0b);
        chk("t4_win_fill", {29'd0, fill_cnt_o}, 32'd4);
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        // last_i on the completing sample ends the sequence: back to FILL.
        chk("t4_end_ready", {31'd0, ready_o}, 32'd1);
        chk("t4_end_fill", {29'd0, fill_cnt_o}, 32'd0);

        // Three windows, then asynchronous reset mid-window
        do_reset();
        for (int s = 1; s <= 4; s++) cyc(1'b1, 1'b0, 1'b0, 8'(s));
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t6_w0_valid", {31'd0, valid_o}, 32'd1);
`ifdef SHIFT_WINDOW_CTRL_IDX_EN
        chk("t6_w0_idx", {16'd0, win_idx_o}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd5);
        cyc(1'b1, 1'b0, 1'b0, 8'd6);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t6_w1_valid", {31'd0, valid_o}, 32'd1);
        chk("t6_w1_data", win_data, 32'h06050403);
`ifdef SHIFT_WINDOW_CTRL_IDX_EN
        chk("t6_w1_idx", {16'd0, win_idx_o}, 32'd1);
`endif
        cyc(1'b0, 1'b0, 1'b1, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd7);
        cyc(1'b1, 1'b0, 1'b0, 8'd8);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t6_w2_valid", {31'd0, valid_o}, 32'd1);
        chk("t6_w2_data", win_data, 32'h08070605);
`ifdef SHIFT_WINDOW_CTRL_IDX_EN
        chk("t6_w2_idx", {16'd0, win_idx_o}, 32'd2);
`endif
        @(posedge clk);
        #1;
        valid_i   = 1'b1;
        din       = 8'd99;
        reset_n_i = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("t6_rst_shen", {31'd0, shift_en_o}, 32'd0);
        chk("t6_rst_fill", {29'd0, fill_cnt_o}, 32'd0);
`ifdef SHIFT_WINDOW_CTRL_IDX_EN
        chk("t6_rst_idx", {16'd0, win_idx_o}, 32'd0);
`endif
        @(posedge clk);
        #2;
        chk("t6_rst_noshift", win_data, 32'h08070605);
        valid_i   = 1'b0;
        reset_n_i = 1'b1;
        #1;
        chk("t6_rel_ready", {31'd0, ready_o}, 32'd1);
        chk("t6_rel_valid", {31'd0, valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
